// File: rtl/led_sequencer.sv
// led_sequencer: byte-commanded LED pattern engine with a programmable
// step timer, four step patterns, global PWM brightness and pause control.
module led_sequencer #(
    parameter int NUM_LEDS = 3,
    parameter int CLK_HZ   = 24_000_000,
    parameter int PWM_BITS = 4
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                cmd_valid,
    input  logic [7:0]          cmd_data,
    output logic                cmd_ready,
    output logic [NUM_LEDS-1:0] led,
    output logic                step_pulse
);

    localparam int TW = $clog2(CLK_HZ + 1);
    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [TW-1:0]       CLK_VAL = TW'(CLK_HZ);
    localparam logic [PW-1:0]       POS_MAX = PW'(NUM_LEDS - 1);
    localparam logic [PWM_BITS-1:0] B_FULL  = '1;

    typedef enum logic [1:0] {
        M_ROTL,
        M_ROTR,
        M_BOUNCE,
        M_BLINK
    } mode_e;

    typedef enum logic [1:0] {
        C_MODE,
        C_SPEED,
        C_BRIGHT,
        C_CTRL
    } cmd_e;

    mode_e               r_mode;
    mode_e               w_mode;
    logic [3:0]          r_sp;
    logic [3:0]          w_sp;
    logic [PWM_BITS-1:0] r_b;
    logic [PWM_BITS-1:0] w_b;
    logic [PWM_BITS-1:0] r_pwm;
    logic                r_pause;
    logic                w_pause;
    logic [PW-1:0]       r_pos;
    logic [PW-1:0]       w_pos;
    logic                r_dir;
    logic                w_dir;
    logic                r_ph;
    logic                w_ph;
    logic [TW-1:0]       r_timer;
    logic [TW-1:0]       w_timer;
    logic [NUM_LEDS-1:0] r_led;
    logic [NUM_LEDS-1:0] w_pat;
    logic                r_step;

    logic                w_accept;
    logic                w_rst_cmd;
    logic                w_tc;
    logic                w_step;
    logic                w_pwm_on;
    logic [TW-1:0]       w_shift;
    logic [TW-1:0]       w_last;
    cmd_e                w_op;
    logic                w_unused;

    assign cmd_ready  = ~rst;
    assign led        = r_led;
    assign step_pulse = r_step;
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_op       = cmd_e'(cmd_data[7:6]);
    assign w_unused   = ^cmd_data[5:4];

    // Command decode; mode, speed and restart all rewind the pattern.
    always_comb begin
        w_mode    = r_mode;
        w_sp      = r_sp;
        w_b       = r_b;
        w_pause   = r_pause;
        w_rst_cmd = 1'b0;
        if (w_accept) begin
            case (w_op)
                C_MODE: begin
                    w_mode    = mode_e'(cmd_data[1:0]);
                    w_rst_cmd = 1'b1;
                end
                C_SPEED: begin
                    w_sp      = cmd_data[3:0];
                    w_rst_cmd = 1'b1;
                end
                C_BRIGHT: begin
                    w_b = cmd_data[PWM_BITS-1:0];
                end
                C_CTRL: begin
                    if (cmd_data[1]) begin
                        w_pause = 1'b0;
                    end else if (cmd_data[0]) begin
                        w_pause = 1'b1;
                    end
                    w_rst_cmd = cmd_data[2];
                end
                default: begin
                    w_rst_cmd = 1'b0;
                end
            endcase
        end
    end

    // Step timer; pause uses the pre-command value.
    always_comb begin
        w_shift = CLK_VAL >> r_sp;
        w_last  = (w_shift == '0) ? '0 : w_shift - TW'(1);
        w_tc    = (r_timer >= w_last);
        w_step  = w_tc & ~r_pause & ~w_rst_cmd;
        if (w_rst_cmd) begin
            w_timer = '0;
        end else if (r_pause) begin
            w_timer = r_timer;
        end else if (w_tc) begin
            w_timer = '0;
        end else begin
            w_timer = r_timer + TW'(1);
        end
    end

    // Pattern position, bounce direction and blink phase.
    always_comb begin
        w_pos = r_pos;
        w_dir = r_dir;
        w_ph  = r_ph;
        if (w_rst_cmd) begin
            w_pos = '0;
            w_dir = 1'b0;
            w_ph  = 1'b0;
        end else if (w_step) begin
            case (r_mode)
                M_ROTL: begin
                    w_pos = (r_pos == POS_MAX) ? '0 : r_pos + PW'(1);
                end
                M_ROTR: begin
                    w_pos = (r_pos == '0) ? POS_MAX : r_pos - PW'(1);
                end
                M_BOUNCE: begin
                    if (NUM_LEDS == 1) begin
                        w_pos = '0;
                    end else if (!r_dir) begin
                        if (r_pos == POS_MAX) begin
                            w_pos = r_pos - PW'(1);
                            w_dir = 1'b1;
                        end else begin
                            w_pos = r_pos + PW'(1);
                        end
                    end else begin
                        if (r_pos == '0) begin
                            w_pos = r_pos + PW'(1);
                            w_dir = 1'b0;
                        end else begin
                            w_pos = r_pos - PW'(1);
                        end
                    end
                end
                M_BLINK: begin
                    w_ph = ~r_ph;
                end
                default: begin
                    w_pos = r_pos;
                end
            endcase
        end
    end

    always_comb begin
        w_pat = '0;
        case (r_mode)
            M_BLINK: w_pat = {NUM_LEDS{r_ph}};
            default: w_pat = NUM_LEDS'(1) << r_pos;
        endcase
        w_pwm_on = (r_b == B_FULL) || (r_pwm < r_b);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_mode  <= M_ROTL;
            r_sp    <= '0;
            r_b     <= B_FULL;
            r_pause <= 1'b0;
            r_pos   <= '0;
            r_dir   <= 1'b0;
            r_ph    <= 1'b0;
            r_timer <= '0;
            r_pwm   <= '0;
            r_led   <= '0;
            r_step  <= 1'b0;
        end else begin
            r_mode  <= w_mode;
            r_sp    <= w_sp;
            r_b     <= w_b;
            r_pause <= w_pause;
            r_pos   <= w_pos;
            r_dir   <= w_dir;
            r_ph    <= w_ph;
            r_timer <= w_timer;
            r_pwm   <= r_pwm + PWM_BITS'(1);
            r_led   <= w_pat & {NUM_LEDS{w_pwm_on}};
            r_step  <= w_step;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer against a step-count based
// reference model, with directed scenarios and random command traffic.
module tb_led_sequencer;

    localparam int N  = 4;
    localparam int HZ = 8;
    localparam int PB = 4;

    logic         clk_in    = 1'b0;
    logic         rst       = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [7:0]   cmd_data  = 8'h00;
    logic         cmd_ready;
    logic [N-1:0] led;
    logic         step_pulse;

    int checks = 0;
    int errors = 0;

    // Model state: k counts steps since the last pattern rewind.
    int m_mode, m_sp, m_b, m_pause, m_k, m_t, m_pwm;
    logic [N-1:0] exp_led;
    logic         exp_step;

    led_sequencer #(
        .NUM_LEDS(N),
        .CLK_HZ  (HZ),
        .PWM_BITS(PB)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .led       (led),
        .step_pulse(step_pulse)
    );

    always #5 clk_in = ~clk_in;

    function automatic int period(int sp);
        int p;
        p = HZ >> sp;
        return (p < 1) ? 1 : p;
    endfunction

    function automatic logic [N-1:0] pattern(int mode, int k);
        logic [N-1:0] one;
        int pos;
        int r;
        one = 1;
        pos = 0;
        case (mode)
            0: pos = k % N;
            1: pos = (N - (k % N)) % N;
            2: begin
                if (N > 1) begin
                    r   = k % (2 * N - 2);
                    pos = (r < N) ? r : (2 * N - 2 - r);
                end
            end
            default: return (k % 2 == 1) ? '1 : '0;
        endcase
        return one << pos;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_sp    = 0;
        m_b     = (1 << PB) - 1;
        m_pause = 0;
        m_k     = 0;
        m_t     = 0;
        m_pwm   = 0;
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        int  op;
        bit  rcmd;
        bit  stp;
        bit  on;
        cmd_valid = v;
        cmd_data  = d;
        op   = int'(d[7:6]);
        rcmd = v && (op == 0 || op == 1 || (op == 3 && d[2]));
        stp  = (m_t == period(m_sp) - 1) && (m_pause == 0) && !rcmd;
        on   = (m_b == (1 << PB) - 1) || (m_pwm < m_b);
        exp_led  = on ? pattern(m_mode, m_k) : '0;
        exp_step = stp;
        m_pwm = (m_pwm + 1) % (1 << PB);
        if (rcmd) begin
            m_k = 0;
            m_t = 0;
        end else if (stp) begin
            m_k++;
            m_t = 0;
        end else if (m_pause == 0) begin
            m_t++;
        end
        if (v) begin
            case (op)
                0: m_mode = int'(d[1:0]);
                1: m_sp   = int'(d[3:0]);
                2: m_b    = int'(d[PB-1:0]);
                default: begin
                    if (d[1]) m_pause = 0;
                    else if (d[0]) m_pause = 1;
                end
            endcase
        end
        @(posedge clk_in);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (led !== '0) begin
            errors++;
            $display("FAIL reset_led got=%b exp=%b", led, 4'b0000);
        end
        checks++;
        if (step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_step got=%b exp=0", step_pulse);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0", cmd_ready);
        end
        rst = 1'b0;
        model_reset();
        tick(1'b0, 8'h00);
        checks++;
        if (led !== 4'b0001) begin
            errors++;
            $display("FAIL first_led got=%b exp=0001", led);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_high got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_rotate();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 8'h00);
            if (step_pulse === 1'b1) pulses++;
            checks++;
            if (led !== exp_led) begin
                errors++;
                $display("FAIL rotate_led got=%b exp=%b t=%0t", led, exp_led, $time);
            end
            checks++;
            if (step_pulse !== exp_step) begin
                errors++;
                $display("FAIL rotate_step got=%b exp=%b t=%0t", step_pulse, exp_step, $time);
            end
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL rotate_pulses got=%0d exp=5", pulses);
        end
    endtask

    task automatic test_modes();
        logic [7:0] cmds [3];
        int         runs [3];
        cmds = '{8'h01, 8'h02, 8'h03};
        runs = '{40, 70, 30};
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, cmds[c]);
            for (int i = 0; i < runs[c]; i++) begin
                tick(1'b0, 8'h00);
                checks++;
                if (led !== exp_led) begin
                    errors++;
                    $display("FAIL mode%0h_led got=%b exp=%b t=%0t", cmds[c], led, exp_led, $time);
                end
                checks++;
                if (step_pulse !== exp_step) begin
                    errors++;
                    $display("FAIL mode%0h_step got=%b exp=%b t=%0t", cmds[c], step_pulse, exp_step, $time);
                end
            end
        end
    endtask

    task automatic test_speed();
        int guard;
        tick(1'b1, 8'h00);
        tick(1'b1, 8'h41);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 8'h00);
            checks++;
            if (led !== exp_led || step_pulse !== exp_step) begin
                errors++;
                $display("FAIL speed4 led=%b/%b step=%b/%b", led, exp_led, step_pulse, exp_step);
            end
        end
        tick(1'b1, 8'h4F);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'h00);
            checks++;
            if (step_pulse !== 1'b1 || led !== exp_led) begin
                errors++;
                $display("FAIL speed1 step=%b exp=1 led=%b exp=%b", step_pulse, led, exp_led);
            end
        end
        tick(1'b1, 8'h40);
        guard = 0;
        while (m_t != period(m_sp) - 1 && guard < 20) begin
            tick(1'b0, 8'h00);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL speed_align got=%0d exp=<20", guard);
        end
        tick(1'b1, 8'h41);
        checks++;
        if (step_pulse !== 1'b0) begin
            errors++;
            $display("FAIL speed_tc_step got=%b exp=0", step_pulse);
        end
        tick(1'b0, 8'h00);
        checks++;
        if (led !== 4'b0001) begin
            errors++;
            $display("FAIL speed_tc_led got=%b exp=0001", led);
        end
    endtask

    task automatic test_pwm();
        logic [7:0] cmds [3];
        int         want [3];
        int         lit;
        cmds = '{8'h85, 8'h80, 8'h8F};
        want = '{5, 0, 16};
        tick(1'b1, 8'h00);
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, cmds[c]);
            lit = 0;
            for (int i = 0; i < 16; i++) begin
                tick(1'b0, 8'h00);
                if (led !== '0) lit++;
                checks++;
                if (led !== exp_led) begin
                    errors++;
                    $display("FAIL pwm%0h_led got=%b exp=%b", cmds[c], led, exp_led);
                end
            end
            checks++;
            if (lit != want[c]) begin
                errors++;
                $display("FAIL pwm%0h_duty got=%0d exp=%0d", cmds[c], lit, want[c]);
            end
        end
    endtask

    task automatic test_pause();
        logic [7:0]   cmds [4];
        int           runs [4];
        logic [N-1:0] held;
        cmds = '{8'hC1, 8'hC2, 8'hC4, 8'hC3};
        runs = '{100, 13, 20, 20};
        tick(1'b1, 8'h40);
        repeat (11) tick(1'b0, 8'h00);
        for (int c = 0; c < 4; c++) begin
            tick(1'b1, cmds[c]);
            held = led;
            for (int i = 0; i < runs[c]; i++) begin
                tick(1'b0, 8'h00);
                checks++;
                if (led !== exp_led || step_pulse !== exp_step) begin
                    errors++;
                    $display("FAIL pause%0h led=%b/%b step=%b/%b", cmds[c], led, exp_led, step_pulse, exp_step);
                end
                if (c == 0) begin
                    checks++;
                    if (led !== held || step_pulse !== 1'b0) begin
                        errors++;
                        $display("FAIL paused_frozen led=%b exp=%b step=%b", led, held, step_pulse);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       v;
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 7) == 0);
            d = 8'($urandom);
            tick(v, d);
            checks++;
            if (led !== exp_led || step_pulse !== exp_step) begin
                errors++;
                $display("FAIL random led=%b/%b step=%b/%b cmd=%b/%h", led, exp_led, step_pulse, exp_step, v, d);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 8'hC2);
        tick(1'b1, 8'h40);
        tick(1'b1, 8'h02);
        tick(1'b1, 8'h85);
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 8'h00);
            checks++;
            if (led !== exp_led) begin
                errors++;
                $display("FAIL bounce_dim got=%b exp=%b", led, exp_led);
            end
            if (i > 10 && exp_led !== '0) break;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (led !== '0 || step_pulse !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_rst led=%b step=%b ready=%b exp=0", led, step_pulse, cmd_ready);
        end
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        model_reset();
        tick(1'b0, 8'h00);
        checks++;
        if (led !== 4'b0001) begin
            errors++;
            $display("FAIL post_rst_led got=%b exp=0001", led);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 8'h00);
            checks++;
            if (led !== exp_led || step_pulse !== exp_step) begin
                errors++;
                $display("FAIL post_rst led=%b/%b step=%b/%b", led, exp_led, step_pulse, exp_step);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotate();
        test_modes();
        test_speed();
        test_pwm();
        test_pause();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern engine with a byte-wide command port, the next generation of the board's fixed three-LED rotator. It drives `NUM_LEDS` outputs in one of four step patterns, with a programmable step rate, global PWM brightness, and pause/restart control. The command port takes one byte per command. It is meant to sit directly behind the UART receive FIFO, so a host can steer the LEDs over the serial link.

## Interface
- `NUM_LEDS`, default 3: number of LED outputs (≥1).
- `CLK_HZ`, default 24_000_000: clock frequency; base step period in cycles.
- `PWM_BITS`, default 4: brightness resolution (1–8).
- `clk_in`  in  1  system clock; sole clock of the block.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command byte present.
- `cmd_data`  in  8  command byte.
- `cmd_ready`  out  1  block can accept a command.
- `led`  out  NUM_LEDS  LED drive, active high.
- `step_pulse`  out  1  one-cycle strobe on every pattern step.

## Operation
- Commands: a byte is accepted when `cmd_valid && cmd_ready`. `cmd_ready` is 0 in reset and 1 at all other times. Decode uses `cmd_data[7:6]`:
  - 00 SET_MODE: mode = `[1:0]`.
  - 01 SET_SPEED: sp = `[3:0]`.
  - 10 SET_BRIGHT: b = `[PWM_BITS-1:0]`; higher bits are ignored.
  - 11 CTRL: `[0]`=1 sets pause, `[1]`=1 clears pause, `[2]`=1 restarts. If `[0]` and `[1]` are both set, clear wins.
- Step timer:
  - Period P = max(1, `CLK_HZ >> sp`). Counter width is `$clog2(CLK_HZ+1)`.
  - Counter runs 0..P-1. When it reaches P-1 it clears and produces a step.
  - While paused, the counter holds and no steps occur.
- Pattern state: position `pos` (0..NUM_LEDS-1), direction `dir` (up/down), blink phase `ph`. Per mode:
  - 0 ROTL: one-hot at `pos`; `pos`+1 per step, wrapping NUM_LEDS-1→0.
  - 1 ROTR: one-hot at `pos`; `pos`-1 per step, wrapping 0→NUM_LEDS-1.
  - 2 BOUNCE: one-hot at `pos`; moves in `dir`. `dir` flips to down at NUM_LEDS-1 and to up at 0, giving 0,1,…,N-1,N-2,…,0,1… with no repeated endpoint. With NUM_LEDS=1, `pos` stays 0.
  - 3 BLINK: all LEDs on when `ph`=1 and off when `ph`=0; `ph` toggles per step.
- SET_MODE, SET_SPEED and restart each reset `pos`=0, `dir`=up, `ph`=0 and timer=0. A SET_MODE with an unchanged mode value still performs this reset.
- PWM:
  - A free-running PWM_BITS counter wraps at 2^PWM_BITS.
  - `pwm_on` = (b == all-ones) || (pwm_cnt < b). b=0 gives fully off.
- `led` = registered (pattern & {NUM_LEDS{`pwm_on`}}).

## Timing
- Reset values:
  - `led`=0, `step_pulse`=0, `cmd_ready`=0.
  - mode=ROTL, sp=0, b=all-ones, pause=0.
  - `pos`=0, `dir`=up, `ph`=0, timer=0, pwm_cnt=0.
- First cycle after reset release: `led`=1 (LSB on).
- Latency:
  - `led` follows the pattern/PWM state by 1 cycle.
  - `step_pulse` is asserted in the same cycle the state advances. The new pattern is visible on `led` the following cycle.
  - An accepted command updates its register on the accepting edge; the effect is visible on `led` one cycle later.
- Simultaneous command and terminal count:
  - SET_MODE/SET_SPEED/restart: the reset takes precedence; no step occurs and `step_pulse`=0.
  - SET_BRIGHT or CTRL pause: the step still occurs, because pause is sampled from its pre-command value.
- Unpausing resumes the timer from its held value.
- Changing brightness never disturbs the timer or the pattern.
- Asserting `rst` mid-operation returns all state to reset values immediately (asynchronous).

## Test plan
- Reset/rotate: CLK_HZ=8, NUM_LEDS=3, no commands → `led` = 001,010,100,001, each held 8 cycles. `step_pulse` fires every 8th cycle.
- Modes: send 0x01 (ROTR) → 001,100,010,001. Send 0x02 with NUM_LEDS=4 → 0001,0010,0100,1000,0100,0010,0001. Send 0x03 → 000,111,000 (all LEDs).
- Speed/boundary: CLK_HZ=8; send 0x41 → period 4. Send 0x4F → period 1: step every cycle with `step_pulse` held high. Send 0x41 on the same cycle as a terminal count → no step that cycle, and `led` returns to 001.
- PWM: PWM_BITS=4, send 0x85 → each lit LED is high exactly 5 of every 16 cycles. Send 0x80 → `led`=0 constantly. Send 0x8F → fully on.
- Pause/restart:
  - Send 0xC1 → `led` frozen and no `step_pulse` for 100 cycles.
  - Send 0xC2 → stepping resumes after the remaining timer cycles.
  - Send 0xC4 mid-pattern → `led`=001 and a full period elapses before the next step.
  - Send 0xC3 → pause stays cleared.
- Async reset: assert `rst` mid-period while in BOUNCE at b=5 → `led`=0 within the same cycle. After release: ROTL, full brightness, `led`=001.
